output_argmax: RTL and testbench
================================

OUTPUT_ARGMAX -- requirements
Module: output_argmax

Interface
REQ-001 Parameter OUTPUT_LEN, default 10: number of output-layer neurons per classification frame.
REQ-002 Parameter ALU_WIDTH, default 12: width of one neuron score, the unsigned pre-activation aggregate.
REQ-003 Parameter IDX_LEN, default 4: width of the class index; the block SHALL require 2^IDX_LEN >= OUTPUT_LEN.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low: rst==0 at a rising edge resets the block.
REQ-006 en  in  1  block enable; en==0 acts as a synchronous clear, identical to reset.
REQ-007 score_valid  in  1  upstream compute stage presents one neuron result.
REQ-008 score_data  in  ALU_WIDTH  aggregate score of the presented neuron.
REQ-009 score_bit  in  1  activated (binarized) output of the presented neuron.
REQ-010 score_last  in  1  marks the final neuron of the frame.
REQ-011 score_ready  out  1  block accepts a beat this cycle.
REQ-012 result_valid  out  1  classification result is held and stable.
REQ-013 result_ack  in  1  consumer takes the result.
REQ-014 class_idx  out  IDX_LEN  index of the maximum-score neuron.
REQ-015 class_score  out  ALU_WIDTH  score of that neuron.
REQ-016 act_vec  out  OUTPUT_LEN  activated bits of the frame; bit i corresponds to neuron i.
REQ-017 frame_err  out  1  sticky flag: score_last was misaligned with the neuron count.

Function
REQ-018 A beat SHALL be accepted only on a rising edge where score_valid && score_ready.
REQ-019 The state machine SHALL have exactly two states: COLLECT (score_ready=1, result_valid=0) and DONE (score_ready=0, result_valid=1).
REQ-020 In COLLECT, an internal counter cnt SHALL count accepted beats from 0; the beat with cnt==i SHALL write act_vec[i] = score_bit.
REQ-021 The first beat of a frame (cnt==0) SHALL load best_score=score_data and best_idx=0 unconditionally.
REQ-022 Each later beat SHALL replace best_score and best_idx only when score_data > best_score (strict, unsigned).
REQ-023 Ties SHALL therefore resolve to the lowest index.
REQ-024 A frame SHALL end on the accepted beat with cnt==OUTPUT_LEN-1, or on an accepted beat with score_last==1, whichever comes first.
REQ-025 At frame end the block SHALL enter DONE on the next cycle, with class_idx, class_score and act_vec valid; latency is 1 cycle from the last accepted beat to result_valid.
REQ-026 If score_last==1 on a beat with cnt < OUTPUT_LEN-1, the block SHALL end the frame early on that beat, set frame_err, and leave unwritten act_vec bits at 0.
REQ-027 If score_last==0 on the beat with cnt==OUTPUT_LEN-1, the block SHALL still end the frame and SHALL set frame_err.
REQ-028 In DONE, score_valid SHALL be ignored and outputs SHALL be held until result_ack==1.
REQ-029 On result_ack==1 in DONE, the next cycle SHALL be COLLECT, with cnt=0 and act_vec cleared.
REQ-030 class_idx and class_score SHALL hold their last values until the next frame ends.
REQ-031 result_ack outside DONE SHALL be ignored.
REQ-032 Once set, frame_err SHALL clear only on reset or en==0.
REQ-033 score_valid and result_ack asserted in the same DONE cycle: the ack is taken, the score is not accepted, and upstream must hold it.

Reset
REQ-034 On rst==0 or en==0 at a rising edge, the block SHALL enter COLLECT with cnt=0, class_idx=0, class_score=0, act_vec=0, result_valid=0, frame_err=0; score_ready SHALL be 1 from the following cycle.
REQ-035 A reset mid-frame or in DONE SHALL discard all partial and held results with no output pulse.

Verification
REQ-036 Ten beats with scores 5,9,3,12,12,0,1,7,2,4, score_bit=1 on beats 1 and 3, last on beat 9 -> result_valid 1 cycle after beat 9, class_idx=3, class_score=12, act_vec=10'b0000001010, frame_err=0.
REQ-037 All ten scores =7 -> class_idx=0, class_score=7.
REQ-038 score_last on the 4th beat with scores 1,2,8,4 -> DONE after beat 3, class_idx=2, class_score=8, act_vec[9:4]=0, frame_err=1.
REQ-039 Hold result_ack=0 for 20 cycles in DONE while score_valid toggles -> score_ready=0 and outputs unchanged; ack with score_valid=1 -> that beat is accepted as beat 0 of the next frame, one cycle after the ack.
REQ-040 Drive rst=0 after 6 beats, then a fresh 10-beat frame with max 4095 at index 9 -> class_idx=9, class_score=4095, no stale bits in act_vec.
REQ-041 en=0 for 1 cycle in DONE -> result_valid=0 and frame_err=0 next cycle, score_ready=1.

Source files
------------

// File: rtl/output_argmax.sv
// output_argmax: collects one frame of output-neuron scores and reports the argmax class, its score and the activated bit vector.
module output_argmax #(
  parameter int OUTPUT_LEN = 10,
  parameter int ALU_WIDTH  = 12,
  parameter int IDX_LEN    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 score_valid,
  input  logic [ALU_WIDTH-1:0] score_data,
  input  logic                 score_bit,
  input  logic                 score_last,
  output logic                 score_ready,
  output logic                 result_valid,
  input  logic                 result_ack,
  output logic [IDX_LEN-1:0]   class_idx,
  output logic [ALU_WIDTH-1:0] class_score,
  output logic [OUTPUT_LEN-1:0] act_vec,
  output logic                 frame_err
);
  if ((2 ** IDX_LEN) < OUTPUT_LEN) begin : g_bad_idx
    $error("IDX_LEN too small for OUTPUT_LEN");
  end
  typedef enum logic {COLLECT, DONE} state_t;
  state_t state, state_nxt;
  logic [IDX_LEN-1:0] cnt, best_idx;
  logic [ALU_WIDTH-1:0] best_score;
  logic clr, accept, at_end, last_beat, take;
  assign clr = !rst || !en;
  assign accept = score_valid && score_ready;
  assign at_end = cnt == IDX_LEN'(OUTPUT_LEN - 1);
  assign last_beat = accept && (at_end || score_last);
  // the first beat of a frame always wins so no stale maximum survives
  assign take = cnt == '0 || score_data > best_score;
  always_ff @(posedge clk)
    state <= clr ? COLLECT : state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == COLLECT) state_nxt = last_beat ? DONE : COLLECT;
    else state_nxt = result_ack ? COLLECT : DONE;
  end
  always_comb begin
    score_ready = state == COLLECT;
    result_valid = state == DONE;
  end
  // class_idx/class_score are separate from the running best so the
  // previous result stays visible while the next frame is collected
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      best_idx <= '0;
      best_score <= '0;
      class_idx <= '0;
      class_score <= '0;
      act_vec <= '0;
      frame_err <= 1'b0;
    end else begin
      if (accept) begin
        act_vec[cnt] <= score_bit;
        cnt <= last_beat ? '0 : cnt + 1'b1;
        if (take) begin
          best_score <= score_data;
          best_idx <= cnt;
        end
        if (last_beat) begin
          class_score <= take ? score_data : best_score;
          class_idx <= take ? cnt : best_idx;
        end
        if (score_last != at_end) frame_err <= 1'b1;
      end
      if (result_valid && result_ack) act_vec <= '0;
    end
  end
endmodule

// File: tb/tb_output_argmax.sv
// tb_output_argmax: directed checks of output_argmax framing, argmax, handshake and clearing.
module tb_output_argmax;
  logic clk = 1'b0;
  logic rst, en, score_valid, score_bit, score_last, result_ack;
  logic [11:0] score_data;
  logic score_ready, result_valid, frame_err;
  logic [3:0] class_idx;
  logic [11:0] class_score;
  logic [9:0] act_vec;
  int checks = 0;
  int errors = 0;
  output_argmax dut (
    .clk(clk), .rst(rst), .en(en), .score_valid(score_valid), .score_data(score_data),
    .score_bit(score_bit), .score_last(score_last), .score_ready(score_ready),
    .result_valid(result_valid), .result_ack(result_ack), .class_idx(class_idx),
    .class_score(class_score), .act_vec(act_vec), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [11:0] d, input logic b, input logic l);
    score_valid = 1'b1;
    score_data = d;
    score_bit = b;
    score_last = l;
    tick();
    score_valid = 1'b0;
    score_bit = 1'b0;
    score_last = 1'b0;
  endtask
  task automatic ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask
  initial begin
    logic [11:0] s1 [10];
    logic [11:0] s4 [10];
    s1 = '{12'd5, 12'd9, 12'd3, 12'd12, 12'd12, 12'd0, 12'd1, 12'd7, 12'd2, 12'd4};
    s4 = '{12'd3, 12'd1, 12'd4, 12'd1, 12'd5, 12'd9, 12'd2, 12'd6, 12'd5, 12'd3};
    rst = 1'b0; en = 1'b1; score_valid = 1'b0; score_data = '0;
    score_bit = 1'b0; score_last = 1'b0; result_ack = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_ready", score_ready, 1);
    chk("rst_valid", result_valid, 0);
    chk("rst_idx", class_idx, 0);
    chk("rst_score", class_score, 0);
    chk("rst_act", act_vec, 0);
    chk("rst_err", frame_err, 0);
    for (int i = 0; i < 10; i++) begin
      beat(s1[i], i == 1 || i == 3, i == 9);
      if (i == 8) chk("f1_not_done", result_valid, 0);
    end
    chk("f1_valid", result_valid, 1);
    chk("f1_ready", score_ready, 0);
    chk("f1_idx", class_idx, 3);
    chk("f1_score", class_score, 12);
    chk("f1_act", act_vec, 10'b0000001010);
    chk("f1_err", frame_err, 0);
    ack();
    chk("ack_valid", result_valid, 0);
    chk("ack_act_clr", act_vec, 0);
    chk("ack_idx_hold", class_idx, 3);
    for (int i = 0; i < 10; i++) begin
      beat(12'd7, 1'b0, i == 9);
      if (i == 0) chk("f2_idx_hold_mid", class_idx, 3);
    end
    chk("f2_idx", class_idx, 0);
    chk("f2_score", class_score, 7);
    ack();
    beat(12'd1, 1'b1, 1'b0);
    beat(12'd2, 1'b1, 1'b0);
    beat(12'd8, 1'b1, 1'b0);
    beat(12'd4, 1'b1, 1'b1);
    chk("f3_valid", result_valid, 1);
    chk("f3_idx", class_idx, 2);
    chk("f3_score", class_score, 8);
    chk("f3_act", act_vec, 10'b0000001111);
    chk("f3_err", frame_err, 1);
    for (int i = 0; i < 20; i++) begin
      score_valid = i[0];
      score_data = 12'($urandom);
      tick();
      chk("hold_ready", score_ready, 0);
      chk("hold_score", class_score, 8);
      chk("hold_act", act_vec, 10'b0000001111);
    end
    score_valid = 1'b1; score_data = 12'd50; score_bit = 1'b1; score_last = 1'b0;
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("ackv_ready", score_ready, 1);
    chk("ackv_valid", result_valid, 0);
    chk("ackv_act", act_vec, 0);
    tick();
    score_valid = 1'b0; score_bit = 1'b0;
    chk("ackv_beat0", act_vec, 10'b0000000001);
    for (int i = 1; i < 10; i++) beat(12'(10 + i), 1'b0, i == 9);
    chk("f4_idx", class_idx, 0);
    chk("f4_score", class_score, 50);
    chk("f4_err_sticky", frame_err, 1);
    en = 1'b0;
    tick();
    en = 1'b1;
    chk("en_valid", result_valid, 0);
    chk("en_err", frame_err, 0);
    chk("en_ready", score_ready, 1);
    chk("en_idx", class_idx, 0);
    for (int i = 0; i < 10; i++) beat(s4[i], 1'b0, 1'b0);
    chk("f5_valid", result_valid, 1);
    chk("f5_idx", class_idx, 5);
    chk("f5_score", class_score, 9);
    chk("f5_err", frame_err, 1);
    ack();
    for (int i = 0; i < 6; i++) beat(12'd4000, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_valid", result_valid, 0);
    chk("mid_rst_act", act_vec, 0);
    chk("mid_rst_score", class_score, 0);
    chk("mid_rst_err", frame_err, 0);
    for (int i = 0; i < 10; i++) begin
      result_ack = i < 9;
      beat(i == 9 ? 12'd4095 : 12'(i * 100), i == 9, i == 9);
    end
    result_ack = 1'b0;
    chk("f6_valid", result_valid, 1);
    chk("f6_idx", class_idx, 9);
    chk("f6_score", class_score, 4095);
    chk("f6_act", act_vec, 10'b1000000000);
    chk("f6_err", frame_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
